// File: rtl/axc_error_sweep_ctrl_if.sv
// Bundle between the sweep controller and the exact/approximate circuits under characterisation.
// The slave side is the controller; the master side drives the request and circuit responses.
interface axc_error_sweep_ctrl_if #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
);
  logic             start;
  logic             abort;
  logic [N_OUT-1:0] et;
  logic [N_IN-1:0]  vec;
  logic [N_OUT-1:0] exact_out;
  logic [N_OUT-1:0] approx_out;
  logic             busy;
  logic             done;
  logic [N_OUT-1:0] max_err;
  logic [N_IN:0]    err_cnt;
  logic             pass;
  logic             fail_valid;
  logic [N_IN-1:0]  first_fail_vec;

  modport master (
    output start, abort, et, exact_out, approx_out,
    input  vec, busy, done, max_err, err_cnt, pass, fail_valid, first_fail_vec
  );

  modport slave (
    input  start, abort, et, exact_out, approx_out,
    output vec, busy, done, max_err, err_cnt, pass, fail_valid, first_fail_vec
  );
endinterface

// File: rtl/axc_error_sweep_ctrl.sv
// Exhaustive error sweep: drives every vector to exact and approximate circuits,
// registers both responses and accumulates max error, violation count and first failing vector.
module axc_error_sweep_ctrl #(
  parameter int N_IN  = 4,
  parameter int N_OUT = 3
) (
  input  logic                    clk,
  input  logic                    rst,
  axc_error_sweep_ctrl_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN} state_t;

  localparam logic [N_IN-1:0] VEC_LAST = '1;

  state_t           state_q, state_d;
  logic [N_IN-1:0]  vec_q, vec_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [N_OUT-1:0] max_err_q, max_err_d;
  logic [N_IN:0]    err_cnt_q, err_cnt_d;
  logic             pass_q, pass_d;
  logic             fail_valid_q, fail_valid_d;
  logic [N_IN-1:0]  ffv_q, ffv_d;
  logic [N_OUT-1:0] et_q, et_d;
  logic             cap_valid_q, cap_valid_d;
  logic [N_OUT-1:0] cap_exact_q, cap_exact_d;
  logic [N_OUT-1:0] cap_approx_q, cap_approx_d;
  logic [N_IN-1:0]  cap_vec_q, cap_vec_d;
  logic [N_OUT-1:0] err;

  always_comb begin
    state_d      = state_q;
    vec_d        = vec_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    max_err_d    = max_err_q;
    err_cnt_d    = err_cnt_q;
    pass_d       = pass_q;
    fail_valid_d = fail_valid_q;
    ffv_d        = ffv_q;
    et_d         = et_q;
    cap_valid_d  = cap_valid_q;
    cap_exact_d  = cap_exact_q;
    cap_approx_d = cap_approx_q;
    cap_vec_d    = cap_vec_q;

    err = (cap_exact_q >= cap_approx_q) ? (cap_exact_q - cap_approx_q)
                                        : (cap_approx_q - cap_exact_q);

    // Compare stage trails capture by one edge; it also runs on the DRAIN edge.
    if (cap_valid_q) begin
      if (err > max_err_q) max_err_d = err;
      if (err > et_q) begin
        err_cnt_d = err_cnt_q + 1'b1;
        if (!fail_valid_q) begin
          fail_valid_d = 1'b1;
          ffv_d        = cap_vec_q;
        end
      end
    end

    case (state_q)
      IDLE: begin
        if (bus.start) begin
          max_err_d    = '0;
          err_cnt_d    = '0;
          pass_d       = 1'b0;
          fail_valid_d = 1'b0;
          ffv_d        = '0;
          et_d         = bus.et;
          vec_d        = '0;
          busy_d       = 1'b1;
          cap_valid_d  = 1'b0;
          state_d      = SWEEP;
        end
      end
      SWEEP: begin
        cap_exact_d  = bus.exact_out;
        cap_approx_d = bus.approx_out;
        cap_vec_d    = vec_q;
        cap_valid_d  = 1'b1;
        if (vec_q == VEC_LAST) state_d = DRAIN;
        else                   vec_d   = vec_q + 1'b1;
      end
      DRAIN: begin
        cap_valid_d = 1'b0;
        busy_d      = 1'b0;
        done_d      = 1'b1;
        pass_d      = (err_cnt_d == '0);
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Abort overrides everything above, including the DRAIN completion.
    if (state_q != IDLE && bus.abort) begin
      state_d      = IDLE;
      vec_d        = '0;
      busy_d       = 1'b0;
      done_d       = 1'b0;
      max_err_d    = '0;
      err_cnt_d    = '0;
      pass_d       = 1'b0;
      fail_valid_d = 1'b0;
      ffv_d        = '0;
      cap_valid_d  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      vec_q        <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      max_err_q    <= '0;
      err_cnt_q    <= '0;
      pass_q       <= 1'b0;
      fail_valid_q <= 1'b0;
      ffv_q        <= '0;
      et_q         <= '0;
      cap_valid_q  <= 1'b0;
      cap_exact_q  <= '0;
      cap_approx_q <= '0;
      cap_vec_q    <= '0;
    end else begin
      state_q      <= state_d;
      vec_q        <= vec_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      max_err_q    <= max_err_d;
      err_cnt_q    <= err_cnt_d;
      pass_q       <= pass_d;
      fail_valid_q <= fail_valid_d;
      ffv_q        <= ffv_d;
      et_q         <= et_d;
      cap_valid_q  <= cap_valid_d;
      cap_exact_q  <= cap_exact_d;
      cap_approx_q <= cap_approx_d;
      cap_vec_q    <= cap_vec_d;
    end
  end

  assign bus.vec            = vec_q;
  assign bus.busy           = busy_q;
  assign bus.done           = done_q;
  assign bus.max_err        = max_err_q;
  assign bus.err_cnt        = err_cnt_q;
  assign bus.pass           = pass_q;
  assign bus.fail_valid     = fail_valid_q;
  assign bus.first_fail_vec = ffv_q;

endmodule

// File: tb/tb_axc_error_sweep_ctrl.sv
// Directed bench for the error sweep controller: small circuit models selected by mode,
// hand-computed sweep results checked with immediate assertions.
module tb_axc_error_sweep_ctrl;

  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;
  int   mode  = 0;

  always #5 clk = ~clk;

  axc_error_sweep_ctrl_if #(.N_IN(4), .N_OUT(3)) bus ();

  axc_error_sweep_ctrl #(.N_IN(4), .N_OUT(3)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Circuit models: 0 identity, 1 |v[1:0]-v[3:2]| vs zero, 2 approx = exact ^ 1
  always_comb begin
    logic [1:0] a, b;
    a = bus.vec[1:0];
    b = bus.vec[3:2];
    bus.exact_out  = '0;
    bus.approx_out = '0;
    case (mode)
      0: begin
        bus.exact_out  = bus.vec[2:0];
        bus.approx_out = bus.vec[2:0];
      end
      1: begin
        bus.exact_out  = {1'b0, ((a >= b) ? (a - b) : (b - a))};
        bus.approx_out = '0;
      end
      default: begin
        bus.exact_out  = bus.vec[2:0];
        bus.approx_out = bus.vec[2:0] ^ 3'd1;
      end
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.done) begin
        lat = k;
        break;
      end
    end
  endtask

  task automatic run_sweep(output int lat);
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    chk("accept_busy", bus.busy, 1);
    chk("accept_vec", bus.vec, 0);
    wait_done(lat);
  endtask

  task automatic chk_cleared(input string tag);
    chk({tag, "_busy"}, bus.busy, 0);
    chk({tag, "_done"}, bus.done, 0);
    chk({tag, "_vec"}, bus.vec, 0);
    chk({tag, "_max"}, bus.max_err, 0);
    chk({tag, "_cnt"}, bus.err_cnt, 0);
    chk({tag, "_pass"}, bus.pass, 0);
    chk({tag, "_fv"}, bus.fail_valid, 0);
    chk({tag, "_ffv"}, bus.first_fail_vec, 0);
  endtask

  task automatic count_done(input int cycles, output int n);
    n = 0;
    for (int k = 0; k < cycles; k++) begin
      step();
      if (bus.done) n++;
    end
  endtask

  initial begin
    int lat, n, p1, p2;
    rst = 1'b1;
    bus.start = 1'b0;
    bus.abort = 1'b0;
    bus.et = '0;
    repeat (2) step();
    chk_cleared("reset");
    rst = 1'b0;

    // identity
    mode = 0; bus.et = 3'd0;
    run_sweep(lat);
    chk("id_lat", lat, 17);
    chk("id_cnt", bus.err_cnt, 0);
    chk("id_max", bus.max_err, 0);
    chk("id_pass", bus.pass, 1);
    chk("id_fv", bus.fail_valid, 0);
    step();
    chk("id_done_1cyc", bus.done, 0);
    chk("id_busy_after", bus.busy, 0);

    // abs-diff model, et=2: violations at vectors 3 and 12
    mode = 1; bus.et = 3'd2;
    run_sweep(lat);
    chk("ad_lat", lat, 17);
    chk("ad_cnt", bus.err_cnt, 2);
    chk("ad_max", bus.max_err, 3);
    chk("ad_ffv", bus.first_fail_vec, 3);
    chk("ad_fv", bus.fail_valid, 1);
    chk("ad_pass", bus.pass, 0);

    // every vector violates
    mode = 2; bus.et = 3'd0;
    run_sweep(lat);
    chk("fv_lat", lat, 17);
    chk("fv_cnt", bus.err_cnt, 16);
    chk("fv_max", bus.max_err, 1);
    chk("fv_ffv", bus.first_fail_vec, 0);
    chk("fv_pass", bus.pass, 0);
    step();
    chk("fv_hold_cnt", bus.err_cnt, 16);
    chk("fv_hold_done", bus.done, 0);

    // abort at vec=4
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (4) step();
    chk("ab_vec4", bus.vec, 4);
    chk("ab_cnt_pre", bus.err_cnt, 3);
    bus.abort = 1'b1;
    step();
    bus.abort = 1'b0;
    chk_cleared("abort");
    count_done(25, n);
    chk("ab_no_done", n, 0);
    chk("ab_idle_busy", bus.busy, 0);
    run_sweep(lat);
    chk("ab_re_lat", lat, 17);
    chk("ab_re_cnt", bus.err_cnt, 16);

    // start held high: one sweep per done
    mode = 0; bus.et = 3'd0;
    bus.start = 1'b1;
    step();
    n = 0; p1 = 0; p2 = 0;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (bus.done) begin
        n++;
        if (n == 1) p1 = k;
        else if (n == 2) p2 = k;
      end
    end
    bus.start = 1'b0;
    chk("held_ndone", n, 2);
    chk("held_p1", p1, 17);
    chk("held_p2", p2, 35);
    wait_done(lat);
    chk("held_last_done", (lat != 0), 1);
    chk("held_pass", bus.pass, 1);

    // et changes mid-sweep; latched 2 still applies
    mode = 1; bus.et = 3'd2;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (3) step();
    bus.et = 3'd0;
    wait_done(lat);
    chk("et_lat", lat, 14);
    chk("et_cnt", bus.err_cnt, 2);
    chk("et_max", bus.max_err, 3);
    chk("et_ffv", bus.first_fail_vec, 3);

    // reset mid-sweep at vec=9
    mode = 2; bus.et = 3'd0;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
    repeat (9) step();
    chk("rs_vec9", bus.vec, 9);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk_cleared("rst_mid");
    count_done(25, n);
    chk("rs_no_done", n, 0);
    chk("rs_idle_busy", bus.busy, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
